// File: rtl/z80_io_capture.sv
// z80_io_capture
//   Captures every CPU OUT cycle seen on a tv80s-style bus into a small FIFO.
//   A consumer drains the FIFO through a valid/ready interface. The CPU can
//   read FIFO status with IN from STATUS_PORT. Writing to STATUS_PORT clears
//   the sticky overflow flag and is not captured.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   iorq_n, m1_n        CPU I/O request / M1 (iorq_n=0 with m1_n=0 is INTA)
//   rd_n, wr_n          CPU read / write strobes
//   addr[15:0], din[7:0] CPU address and data-out buses
//   dout[7:0], dout_en  status byte returned to the CPU, and its drive enable
//   q_valid, q_ready    FIFO head handshake
//   q_port[15:0], q_data[7:0] FIFO head entry (zero when empty)
//   overflow            sticky: a write was dropped because the FIFO was full
module z80_io_capture #(
  parameter int          DEPTH       = 8,     // 2, 4 or 8
  parameter logic [7:0]  STATUS_PORT = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [15:0] q_port,
  output logic [7:0]  q_data,
  output logic        overflow
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  // State
  logic          wr_act_d_q, wr_act_d_d;
  logic          boot_q, boot_d;          // high only until the first clock after reset
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   mem_port_q [DEPTH];
  logic [7:0]    mem_data_q [DEPTH];

  // Decode
  logic wr_act, rd_act, wr_rise, status_hit;
  logic ctrl_wr, push_req, push, pop, full, empty;

  always_comb begin
    wr_act     = !iorq_n && !wr_n && m1_n;
    rd_act     = !iorq_n && !rd_n && m1_n;
    status_hit = (addr[7:0] == STATUS_PORT);
    // On the first clock after reset the previous strobe is treated as high,
    // so a write cycle already in progress at release is not captured.
    wr_rise    = wr_act && !(wr_act_d_q || boot_q);
    ctrl_wr    = wr_rise && status_hit;
    push_req   = wr_rise && !status_hit;
    full       = (count_q == FULL_CNT);
    empty      = (count_q == 4'd0);
    pop        = !empty && q_ready;
    // When full, a push is only accepted if a pop frees the slot this edge.
    push       = push_req && (!full || pop);
  end

  // NOTE: every signal assigned in always_comb gets a default first; this
  // is what keeps the block free of inferred latches.
  always_comb begin
    wr_act_d_d = wr_act;
    boot_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);   // DEPTH is a power of two: natural wrap
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    // Clear first so that a set on the same edge wins.
    if (ctrl_wr)                     overflow_d = 1'b0;
    if (push_req && full && !pop)    overflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act_d_q <= 1'b0;
      boot_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_act_d_q <= wr_act_d_d;
      boot_q     <= boot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the outputs are masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_port_q[wr_ptr_q] <= addr;
      mem_data_q[wr_ptr_q] <= din;
    end
  end

  // Outputs
  always_comb begin
    q_valid  = !empty;
    q_port   = empty ? 16'h0000 : mem_port_q[rd_ptr_q];
    q_data   = empty ? 8'h00    : mem_data_q[rd_ptr_q];
    overflow = overflow_q;
    dout_en  = rd_act && status_hit;
    dout     = dout_en ? {overflow_q, full, empty, 1'b0, count_q} : 8'h00;
  end

endmodule

// File: tb/tb_z80_io_capture.sv
// Self-checking bench for z80_io_capture (DEPTH=8, STATUS_PORT=8'hFF).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_z80_io_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        iorq_n, m1_n, rd_n, wr_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_en;
  logic        q_valid, q_ready;
  logic [15:0] q_port;
  logic [7:0]  q_data;
  logic        overflow;

  z80_io_capture #(.DEPTH(8), .STATUS_PORT(8'hFF)) dut (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n),
    .wr_n(wr_n), .addr(addr), .din(din), .dout(dout), .dout_en(dout_en),
    .q_valid(q_valid), .q_ready(q_ready), .q_port(q_port), .q_data(q_data),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: entries the FIFO must hold, oldest first, plus model overflow.
  typedef struct packed {
    logic [15:0] port;
    logic [7:0]  data;
  } entry_t;
  entry_t sb[$];
  logic   movf = 1'b0;

  typedef struct {
    logic        iorq_n, m1_n, rd_n, wr_n;
    logic [15:0] addr;
    logic        exp_en;
    logic [7:0]  exp_dout;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {movf, sb.size() == 8, sb.size() == 0, 1'b0, 4'(sb.size())};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  // One OUT cycle with the strobe held for 'hold' clocks; the model is updated
  // as the capture logic should see it (no pop in parallel).
  task automatic out_cycle(input logic [15:0] a, input logic [7:0] d, input int hold);
    if (a[7:0] == 8'hFF) movf = 1'b0;
    else if (sb.size() < 8) sb.push_back({a, d});
    else movf = 1'b1;
    addr = a; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (hold) step();
    bus_idle();
    step();
  endtask

  task automatic check_status(input string name);
    addr = 16'h00FF; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check({name, " dout_en"}, 32'(dout_en), 32'd1);
    check({name, " dout"}, 32'(dout), 32'(exp_status()));
    bus_idle();
    #1;
  endtask

  task automatic pop_one(input string name);
    entry_t e;
    if (sb.size() == 0) begin
      check({name, " model entry available"}, 32'(q_valid), 32'd0);
      return;
    end
    e = sb.pop_front();
    check({name, " q_valid"}, 32'(q_valid), 32'd1);
    check({name, " q_port"}, 32'(q_port), 32'(e.port));
    check({name, " q_data"}, 32'(q_data), 32'(e.data));
    q_ready = 1'b1;
    step();
    q_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t h;
    reset = 1'b1; q_ready = 1'b0; addr = 16'h0000; din = 8'h00;
    bus_idle();
    #1;
    check("reset q_valid", 32'(q_valid), 32'd0);
    check("reset q_port", 32'(q_port), 32'd0);
    check("reset q_data", 32'(q_data), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset dout_en", 32'(dout_en), 32'd0);
    #12 reset = 1'b0;
    step();
    check_status("empty after reset");

    // Single OUT (C),C with BC=59EC, strobe held for 3 clocks.
    addr = 16'h59EC; din = 8'hEC; iorq_n = 1'b0; wr_n = 1'b0;
    #1;
    check("single no bypass", 32'(q_valid), 32'd0);
    step();
    check("single latency q_valid", 32'(q_valid), 32'd1);
    check("single latency q_port", 32'(q_port), 32'h59EC);
    step(); step();
    bus_idle();
    step();
    sb.push_back({16'h59EC, 8'hEC});
    check_status("single count");
    pop_one("single pop");
    check_status("single drained");

    // Fill and overflow: 9 distinct OUTs.
    for (int i = 0; i < 9; i++)
      out_cycle(16'h1000 + 16'(i * 16'h0111), 8'(8'h10 + i * 3), 1);
    check("fill overflow flag", 32'(overflow), 32'd1);
    check_status("fill status C8");
    check("fill status literal", 32'(exp_status()), 32'hC8);

    // Control write clears overflow; count stays 8.
    out_cycle(16'h00FF, 8'h55, 1);
    check("clear overflow flag", 32'(overflow), 32'd0);
    check_status("clear status 48");

    // Full FIFO, push and pop on the same edge.
    h = sb.pop_front();
    check("simul head port", 32'(q_port), 32'(h.port));
    sb.push_back({16'h7E11, 8'hA5});
    q_ready = 1'b1;
    addr = 16'h7E11; din = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
    step();
    q_ready = 1'b0;
    bus_idle();
    step();
    check("simul overflow", 32'(overflow), 32'd0);
    check_status("simul status");
    for (int i = 0; i < 8; i++) pop_one($sformatf("drain %0d", i));
    check_status("drained");
    check("empty q_port", 32'(q_port), 32'd0);
    check("empty q_data", 32'(q_data), 32'd0);

    // Pop requests on an empty FIFO must not move the pointers.
    q_ready = 1'b1;
    step(); step();
    q_ready = 1'b0;
    check_status("empty ready");
    out_cycle(16'h0102, 8'h03, 1);
    pop_one("after empty ready");

    // INTA, reads and M1 writes: decode table, with two entries queued.
    out_cycle(16'h2211, 8'h31, 1);
    out_cycle(16'h2212, 8'h32, 2);
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0038, 1'b0, 8'h00};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h12FF, 1'b1, exp_status()};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF, 1'b0, 8'h00};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 8'h00};
    for (int i = 0; i < 6; i++) begin
      iorq_n = vt[i].iorq_n; m1_n = vt[i].m1_n; rd_n = vt[i].rd_n;
      wr_n = vt[i].wr_n; addr = vt[i].addr; din = 8'hC3;
      #1;
      check($sformatf("vec %0d dout_en", i), 32'(dout_en), 32'(vt[i].exp_en));
      check($sformatf("vec %0d dout", i), 32'(dout), 32'(vt[i].exp_dout));
      step(); step();
      bus_idle();
      step();
    end
    check_status("after decode table");
    pop_one("table pop 0");
    pop_one("table pop 1");

    // Reset in the middle of an OUT cycle with 3 entries queued.
    for (int i = 0; i < 3; i++) out_cycle(16'h3001 + 16'(i), 8'(8'h40 + i), 1);
    addr = 16'hABCD; din = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
    #3 reset = 1'b1;
    #1;
    sb.delete();
    movf = 1'b0;
    check("midreset q_valid", 32'(q_valid), 32'd0);
    check("midreset q_port", 32'(q_port), 32'd0);
    check("midreset q_data", 32'(q_data), 32'd0);
    #2 reset = 1'b0;
    step();
    check("release no capture", 32'(q_valid), 32'd0);
    step(); step();
    check("held no capture", 32'(q_valid), 32'd0);
    bus_idle();
    step();
    check_status("after midreset");
    out_cycle(16'h4321, 8'h77, 1);
    pop_one("post reset capture");
    check_status("final empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
